// File: rtl/icache_pkg.sv
// Shared types for the direct-mapped instruction cache: address fields, frame
// layout and controller state.
package icache_pkg;

    localparam int SETS  = 16;
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 32 - IDX_W - 2;

    typedef logic [31:0] word_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] idx;
        logic [1:0]       bytoff;
    } icachef_t;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        word_t            data;
    } icache_frame_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: same-cycle hits, one-word fills
// from the memory controller on a miss, plus hit/fill performance counters.
module icache
    import icache_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    icache_frame_t               r_frames [SETS];
    icache_state_t               r_state;
    logic [TAG_W+IDX_W-1:0]      r_miss_addr;
    logic                        r_iren;
    logic [31:0]                 r_iaddr;
    logic [31:0]                 r_hit_cnt;
    logic [31:0]                 r_miss_cnt;

    icachef_t                    w_req;
    icache_frame_t               w_frame;
    logic                        w_hit;
    word_t                       w_load;
    logic                        w_fill;
    icache_state_t               w_next_state;
    logic [IDX_W-1:0]            w_fill_idx;
    logic [TAG_W-1:0]            w_fill_tag;

    assign w_req      = imemaddr;
    assign w_frame    = r_frames[w_req.idx];
    assign w_fill_idx = r_miss_addr[IDX_W-1:0];
    assign w_fill_tag = r_miss_addr[TAG_W+IDX_W-1:IDX_W];

    // Hit detection, fill acceptance and next-state selection.
    always_comb begin
        w_hit        = 1'b0;
        w_load       = 32'h0000_0000;
        w_fill       = 1'b0;
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (imemREN && w_frame.valid && (w_frame.tag == w_req.tag)) begin
                    w_hit  = 1'b1;
                    w_load = w_frame.data;
                end else if (imemREN) begin
                    w_next_state = FETCH;
                end else begin
                    w_next_state = IDLE;
                end
            end
            FETCH: begin
                // Fill completes regardless of what the fetch port does now.
                if (!iwait) begin
                    w_fill       = 1'b1;
                    w_next_state = IDLE;
                end else begin
                    w_next_state = FETCH;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Controller state, miss address and registered fill request outputs.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state     <= IDLE;
            r_miss_addr <= '0;
            r_iren      <= 1'b0;
            r_iaddr     <= 32'h0000_0000;
        end else begin
            r_state <= w_next_state;
            if ((r_state == IDLE) && (w_next_state == FETCH)) begin
                r_miss_addr <= {w_req.tag, w_req.idx};
                r_iren      <= 1'b1;
                r_iaddr     <= {w_req.tag, w_req.idx, 2'b00};
            end else if (w_next_state == IDLE) begin
                r_iren      <= 1'b0;
                r_iaddr     <= 32'h0000_0000;
            end else begin
                r_iren      <= r_iren;
                r_iaddr     <= r_iaddr;
            end
        end
    end

    // Frame array: a fill evicts whatever occupies the indexed frame.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < SETS; i++) begin
                r_frames[i] <= '0;
            end
        end else begin
            if (w_fill) begin
                r_frames[w_fill_idx] <= '{valid: 1'b1, tag: w_fill_tag, data: iload};
            end
        end
    end

    // Performance counters, wrapping modulo 2^32.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_hit_cnt  <= 32'h0000_0000;
            r_miss_cnt <= 32'h0000_0000;
        end else begin
            if (w_hit) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end
            if (w_fill) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign ihit     = w_hit;
    assign imemload = w_load;
    assign iREN     = r_iren;
    assign iaddr    = r_iaddr;
    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: stimulus queues expected hits and fills, a
// negedge monitor pops and compares whenever the cache presents one.
module tb_icache;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          ren_cycles = 0;
    logic [31:0] hit_q  [$];
    logic [31:0] fill_q [$];

    icache dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Miss on a, optionally redirect the fetch port to redirect_a during FETCH,
    // hold iwait for waits cycles, then deliver d.
    task automatic miss_fill(input logic [31:0] a, input int waits,
                             input logic [31:0] d, input logic [31:0] redirect_a);
        imemREN  = 1'b1;
        imemaddr = a;
        iwait    = 1'b1;
        fill_q.push_back(a & 32'hFFFF_FFFC);
        #1;
        check("miss_ihit", {31'd0, ihit}, 32'd0);
        step();
        imemaddr = redirect_a;
        repeat (waits) step();
        iwait = 1'b0;
        iload = d;
        step();
        iwait = 1'b1;
        iload = 32'h0000_0000;
    endtask

    task automatic hit(input logic [31:0] a, input logic [31:0] d, input int n);
        imemREN  = 1'b1;
        imemaddr = a;
        for (int i = 0; i < n; i++) begin
            hit_q.push_back(d);
            step();
        end
    endtask

    // Monitor: compares every presented hit and every accepted fill request.
    always @(negedge CLK) begin
        if (nRST === 1'b1) begin
            if (iREN) ren_cycles++;
            if (ihit) begin
                n_tests++;
                if (hit_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_hit: got ihit=1 addr 0x%08h expected ihit=0", imemaddr);
                end else begin
                    logic [31:0] e;
                    e = hit_q.pop_front();
                    if (imemload !== e) begin
                        n_fail++;
                        $display("FAIL hit_data: got 0x%08h expected 0x%08h", imemload, e);
                    end
                end
            end else begin
                check("miss_load_zero", imemload, 32'h0000_0000);
            end
            if (iREN && !iwait) begin
                n_tests++;
                if (fill_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_fill: got iaddr 0x%08h expected no fill", iaddr);
                end else begin
                    logic [31:0] e;
                    e = fill_q.pop_front();
                    if (iaddr !== e) begin
                        n_fail++;
                        $display("FAIL fill_addr: got 0x%08h expected 0x%08h", iaddr, e);
                    end
                end
            end
        end
    end

    initial begin
        nRST     = 1'b0;
        imemREN  = 1'b0;
        imemaddr = 32'h0000_0000;
        iwait    = 1'b1;
        iload    = 32'h0000_0000;
        #12;
        check("rst_ihit", {31'd0, ihit}, 32'd0);
        check("rst_imemload", imemload, 32'h0);
        check("rst_iREN", {31'd0, iREN}, 32'd0);
        check("rst_iaddr", iaddr, 32'h0);
        check("rst_hit_cnt", hit_cnt, 32'd0);
        check("rst_miss_cnt", miss_cnt, 32'd0);
        nRST = 1'b1;
        step();

        // Cold miss, 3 wait cycles.
        miss_fill(32'h0000_0040, 3, 32'h2001_0005, 32'h0000_0040);
        check("cold_ren_cycles", ren_cycles, 32'd4);
        check("cold_miss_cnt", miss_cnt, 32'd1);
        hit(32'h0000_0040, 32'h2001_0005, 1);

        // Hit streak and byte-offset fetch.
        hit(32'h0000_0040, 32'h2001_0005, 5);
        check("streak_hit_cnt", hit_cnt, 32'd6);
        hit(32'h0000_0043, 32'h2001_0005, 1);
        check("byteoff_hit_cnt", hit_cnt, 32'd7);

        // Conflict on index 0.
        miss_fill(32'h0000_0080, 2, 32'hAAAA_0001, 32'h0000_0080);
        hit(32'h0000_0080, 32'hAAAA_0001, 1);
        miss_fill(32'h0000_0040, 1, 32'h2001_0005, 32'h0000_0040);
        hit(32'h0000_0040, 32'h2001_0005, 2);
        check("conflict_miss_cnt", miss_cnt, 32'd3);

        // Redirect mid-fill: 0x44 fill completes, then 0x100 misses.
        miss_fill(32'h0000_0044, 2, 32'hBBBB_0002, 32'h0000_0100);
        miss_fill(32'h0000_0100, 0, 32'hCCCC_0003, 32'h0000_0100);
        hit(32'h0000_0100, 32'hCCCC_0003, 1);
        hit(32'h0000_0044, 32'hBBBB_0002, 1);
        check("flush_miss_cnt", miss_cnt, 32'd5);
        check("flush_hit_cnt", hit_cnt, 32'd12);

        // Reset during a fill.
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0200;
        iwait    = 1'b1;
        step();
        check("midfill_iREN", {31'd0, iREN}, 32'd1);
        check("midfill_iaddr", iaddr, 32'h0000_0200);
        #2;
        nRST = 1'b0;
        #1;
        check("async_iREN", {31'd0, iREN}, 32'd0);
        check("async_iaddr", iaddr, 32'h0);
        check("async_miss_cnt", miss_cnt, 32'd0);
        imemaddr = 32'h0000_0044;
        #1;
        check("async_ihit", {31'd0, ihit}, 32'd0);
        #3;
        nRST = 1'b1;
        step();
        miss_fill(32'h0000_0044, 1, 32'hDDDD_0004, 32'h0000_0044);
        hit(32'h0000_0044, 32'hDDDD_0004, 1);
        check("post_rst_miss_cnt", miss_cnt, 32'd1);

        imemREN = 1'b0;
        step();
        step();
        check("hit_q_empty", hit_q.size(), 32'd0);
        check("fill_q_empty", fill_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
